// File: rtl/or16_rr_arbiter.sv
// Round-robin arbiter that shares one 16-bit OR core among NREQ requesters.
// The winner's a|b and index are captured in a single output register with valid/ready handshake.

module gor16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

module or16_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NREQ-1:0]                              req,
  input  logic [NREQ*WIDTH-1:0]                        a_bus,
  input  logic [NREQ*WIDTH-1:0]                        b_bus,
  output logic [NREQ-1:0]                              gnt,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [WIDTH-1:0]                             rsp_y,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]   rsp_id
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [IDW-1:0]   id_q, id_d;

  logic             found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic             can_accept;
  logic             grant_en;
  logic [WIDTH-1:0] a_sel, b_sel, or_y;

  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign grant_en   = rst_n && can_accept && found;

  // Scan starting at ptr_q and wrapping, first set request wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = IDW'((int'(ptr_q) + j) % NREQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gnt   = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        gnt[i] = grant_en;
        a_sel  = a_bus[i*WIDTH +: WIDTH];
        b_sel  = b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // The shared core is fixed at 16 bits, so WIDTH must stay 16.
  gor16 u_gor16 (
    .a_i (a_sel),
    .b_i (b_sel),
    .y_o (or_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    id_d    = id_q;
    if (grant_en) begin
      state_d = FULL;
      y_d     = or_y;
      id_d    = win_idx;
      ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      y_q     <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_y     = y_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_or16_rr_arbiter.sv
// Scenario bench for or16_rr_arbiter: directed cases plus random traffic checked
// against a queue-free round-robin reference model.

module tb_or16_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus, b_bus;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid, rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic [IDW-1:0]        rsp_id;

  int total = 0;
  int bad   = 0;

  // Reference state
  int               m_ptr;
  bit               m_valid;
  logic [WIDTH-1:0] m_y;
  int               m_id;

  or16_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    int k;
    g = '0;
    if (!rst_n) return g;
    if (m_valid && !rsp_ready) return g;
    for (int j = 0; j < NREQ; j++) begin
      k = (m_ptr + j) % NREQ;
      if (req[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(input logic [NREQ-1:0] g);
    int k;
    k = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) k = i;
    if (k >= 0) begin
      m_y     = a_bus[k*WIDTH +: WIDTH] | b_bus[k*WIDTH +: WIDTH];
      m_id    = k;
      m_valid = 1'b1;
      m_ptr   = (k + 1) % NREQ;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_y = '0; m_id = 0;
  endtask

  // Samples gnt mid-cycle, advances one clock and the model, returns #1 after the edge.
  task automatic cycle(output logic [NREQ-1:0] g_obs, output logic [NREQ-1:0] g_exp);
    @(negedge clk);
    g_obs = gnt;
    g_exp = model_gnt();
    @(posedge clk);
    model_edge(g_exp);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_bus[i*WIDTH +: WIDTH] = a;
    b_bus[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rsp_ready = 1'b0; a_bus = '0; b_bus = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NREQ-1:0] g, ge;
    rst_n = 1'b0; req = 4'b1111; rsp_ready = 1'b1;
    model_reset();
    #2;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
    total++; if ({rsp_valid, rsp_y, rsp_id} !== 19'd0) begin bad++;
      $display("FAIL rst_state valid=%b y=%h id=%0d want all zero", rsp_valid, rsp_y, rsp_id); end
    req = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_op(0, 16'hA5A5, 16'h0101); req = 4'b0001; rsp_ready = 1'b0;
    cycle(g, ge);
    total++; if (rsp_valid !== 1'b1 || rsp_y !== 16'hA5A5) begin bad++;
      $display("FAIL rst_prefill valid=%b y=%h want 1/a5a5", rsp_valid, rsp_y); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_y !== 16'h0000 || gnt !== 4'b0000) begin bad++;
      $display("FAIL rst_async valid=%b y=%h gnt=%b want 0/0000/0000", rsp_valid, rsp_y, gnt); end
    model_reset();
    req = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g, ge;
    do_reset();
    set_op(0, 16'h00F0, 16'h0F00); req = 4'b0001; rsp_ready = 1'b1;
    cycle(g, ge);
    total++; if (g !== 4'b0001 || g !== ge) begin bad++; $display("FAIL single_gnt got=%b want=0001", g); end
    total++; if (rsp_valid !== 1'b1 || rsp_y !== 16'h0FF0 || rsp_id !== 2'd0) begin bad++;
      $display("FAIL single_rsp valid=%b y=%h id=%0d want 1/0ff0/0", rsp_valid, rsp_y, rsp_id); end
  endtask

  task automatic test_rotate();
    logic [NREQ-1:0] g, ge, want;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(1 << i), 16'h0000);
    req = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      want = 4'b0001 << (c % 4);
      cycle(g, ge);
      total++; if (g !== want || g !== ge) begin bad++; $display("FAIL rotate_gnt c=%0d got=%b want=%b", c, g, want); end
      total++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(c % 4) || rsp_y !== 16'(1 << (c % 4))) begin bad++;
        $display("FAIL rotate_rsp c=%0d valid=%b id=%0d y=%h want id=%0d", c, rsp_valid, rsp_id, rsp_y, c % 4); end
    end
  endtask

  task automatic test_stall();
    logic [NREQ-1:0] g, ge;
    do_reset();
    set_op(1, 16'h1234, 16'h0008); req = 4'b0010; rsp_ready = 1'b0;
    cycle(g, ge);
    total++; if (g !== 4'b0010 || rsp_y !== 16'h123C || rsp_id !== 2'd1) begin bad++;
      $display("FAIL stall_fill gnt=%b y=%h id=%0d want 0010/123c/1", g, rsp_y, rsp_id); end
    set_op(1, 16'hFF00, 16'h0008);
    for (int c = 0; c < 3; c++) begin
      cycle(g, ge);
      total++; if (g !== 4'b0000 || rsp_valid !== 1'b1 || rsp_y !== 16'h123C || rsp_id !== 2'd1) begin bad++;
        $display("FAIL stall_hold c=%0d gnt=%b valid=%b y=%h id=%0d want 0000/1/123c/1", c, g, rsp_valid, rsp_y, rsp_id); end
    end
    rsp_ready = 1'b1;
    cycle(g, ge);
    total++; if (g !== 4'b0010 || rsp_valid !== 1'b1 || rsp_y !== 16'hFF08) begin bad++;
      $display("FAIL stall_release gnt=%b valid=%b y=%h want 0010/1/ff08", g, rsp_valid, rsp_y); end
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] g, ge;
    do_reset();
    set_op(0, 16'h0001, 16'h0010); set_op(2, 16'h0200, 16'h0000); set_op(3, 16'h8000, 16'h0003);
    req = 4'b0100; rsp_ready = 1'b1;
    cycle(g, ge);
    total++; if (g !== 4'b0100) begin bad++; $display("FAIL wrap_g2 got=%b want=0100", g); end
    req = 4'b1001;
    cycle(g, ge);
    total++; if (g !== 4'b1000 || rsp_id !== 2'd3 || rsp_y !== 16'h8003) begin bad++;
      $display("FAIL wrap_g3 gnt=%b id=%0d y=%h want 1000/3/8003", g, rsp_id, rsp_y); end
    cycle(g, ge);
    total++; if (g !== 4'b0001 || rsp_id !== 2'd0 || rsp_y !== 16'h0011) begin bad++;
      $display("FAIL wrap_g0 gnt=%b id=%0d y=%h want 0001/0/0011", g, rsp_id, rsp_y); end
  endtask

  task automatic test_idle();
    logic [NREQ-1:0] g, ge;
    do_reset();
    set_op(1, 16'h0055, 16'h0000); req = 4'b0010; rsp_ready = 1'b1;
    cycle(g, ge);
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      cycle(g, ge);
      total++; if (g !== 4'b0000 || rsp_valid !== 1'b0) begin bad++;
        $display("FAIL idle_drain c=%0d gnt=%b valid=%b want 0000/0", c, g, rsp_valid); end
    end
    req = 4'b1111;
    cycle(g, ge);
    total++; if (g !== 4'b0100 || rsp_id !== 2'd2) begin bad++;
      $display("FAIL idle_ptr gnt=%b id=%0d want 0100/2", g, rsp_id); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g, ge;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req       = NREQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
      cycle(g, ge);
      total++; if (g !== ge) begin bad++; $display("FAIL rand_gnt c=%0d got=%b want=%b", c, g, ge); end
      total++; if (rsp_valid !== m_valid || (m_valid && (rsp_y !== m_y || rsp_id !== IDW'(m_id)))) begin bad++;
        $display("FAIL rand_rsp c=%0d valid=%b y=%h id=%0d want %b/%h/%0d", c, rsp_valid, rsp_y, rsp_id, m_valid, m_y, m_id); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; rsp_ready = 1'b0; a_bus = '0; b_bus = '0;
    model_reset();
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_wrap();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
